// File: rtl/rx_pattern_checker.sv
// rx_pattern_checker: sinks the user RX stream, checks the incrementing-byte
// pattern, keeps byte/error/window statistics. Optional macro: RX_CHECK_BACKPRESSURE_EN.
module rx_pattern_checker #(
  parameter int unsigned  WINDOW_CYCLES = 156_250_000,
  parameter logic [15:0]  LFSR_SEED     = 16'hACE1
) (
  input  logic        coreclk_out,
  input  logic        reset,
  input  logic        check_en,
  input  logic        clear,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  output logic        rx_active,
  output logic [63:0] rx_byte_count,
  output logic        err_flag,
  output logic [31:0] err_count,
  output logic [31:0] tkeep_err_count,
  output logic [63:0] first_err_offset,
  output logic [63:0] window_bytes,
  output logic        window_valid
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  exp_q;
  logic [31:0] cyc_cnt;
  logic [63:0] win_acc;

  logic [3:0]  n_bytes;
  logic [7:0]  mis;
  logic [2:0]  k_min;
  logic [7:0]  last_byte;
  logic        keep_legal;
  logic        fire;
  logic        beat;
  logic        keep_bad;
  logic [63:0] beat_bytes;
  logic        win_end;

  // Per-beat decode: lane count, lane mismatches, lowest bad lane, last lane
  always_comb begin
    n_bytes   = 4'd0;
    mis       = 8'd0;
    k_min     = 3'd0;
    last_byte = 8'd0;
    for (int k = 0; k < 8; k++) begin
      if (s_axis_tkeep[k]) begin
        n_bytes   = n_bytes + 4'd1;
        last_byte = s_axis_tdata[8*k +: 8];
      end
      mis[k] = s_axis_tkeep[k] &&
               (s_axis_tdata[8*k +: 8] != exp_q + 8'(k));
    end
    for (int k = 7; k >= 0; k--) begin
      if (mis[k]) k_min = 3'(k);
    end
  end

  assign keep_legal = (s_axis_tkeep != 8'd0) &&
                      ((s_axis_tkeep & (s_axis_tkeep + 8'd1)) == 8'd0);
  assign fire       = s_axis_tvalid & s_axis_tready & check_en & ~clear;
  assign beat       = fire & keep_legal;
  assign keep_bad   = fire & ~keep_legal & (s_axis_tkeep != 8'd0);
  assign beat_bytes = beat ? {60'd0, n_bytes} : 64'd0;
  assign win_end    = (state == RUN) && (cyc_cnt == WINDOW_CYCLES);
  assign rx_active  = (state == RUN);

  // Window FSM state register
  always_ff @(posedge coreclk_out) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Window FSM next state: first counted beat starts, only clear stops
  always_comb begin
    state_nxt = state;
    if (clear)                      state_nxt = IDLE;
    else if (state == IDLE && beat) state_nxt = RUN;
  end

  // Statistics, expected pattern and window accumulation
  always_ff @(posedge coreclk_out) begin
    if (reset || clear) begin
      exp_q            <= 8'd0;
      rx_byte_count    <= 64'd0;
      err_flag         <= 1'b0;
      err_count        <= 32'd0;
      tkeep_err_count  <= 32'd0;
      first_err_offset <= 64'd0;
      window_bytes     <= 64'd0;
      window_valid     <= 1'b0;
      cyc_cnt          <= 32'd0;
      win_acc          <= 64'd0;
    end else begin
      window_valid <= 1'b0;
      if (keep_bad && tkeep_err_count != 32'hFFFF_FFFF)
        tkeep_err_count <= tkeep_err_count + 32'd1;
      if (beat) begin
        rx_byte_count <= rx_byte_count + beat_bytes;
        if (mis != 8'd0) begin
          if (err_count != 32'hFFFF_FFFF)
            err_count <= err_count + 32'd1;
          if (!err_flag) begin
            first_err_offset <= rx_byte_count + {61'd0, k_min};
            err_flag         <= 1'b1;
          end
          exp_q <= last_byte + 8'd1;
        end else begin
          exp_q <= exp_q + {4'd0, n_bytes};
        end
      end
      if (state == IDLE) begin
        if (beat) begin
          cyc_cnt <= 32'd1;
          win_acc <= beat_bytes;
        end
      end else if (win_end) begin
        window_bytes <= win_acc + beat_bytes;
        window_valid <= 1'b1;
        cyc_cnt      <= 32'd1;
        win_acc      <= 64'd0;
      end else begin
        cyc_cnt <= cyc_cnt + 32'd1;
        win_acc <= win_acc + beat_bytes;
      end
    end
  end

`ifdef RX_CHECK_BACKPRESSURE_EN
  logic [15:0] lfsr;

  // Pseudo-random ready, roughly 75% duty
  always_ff @(posedge coreclk_out) begin
    if (reset || clear) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Registered ready derived from the LFSR
  always_ff @(posedge coreclk_out) begin
    if (reset) s_axis_tready <= 1'b0;
    else       s_axis_tready <= lfsr[0] | lfsr[1];
  end
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;

  // Always ready once out of reset
  always_ff @(posedge coreclk_out) begin
    if (reset) s_axis_tready <= 1'b0;
    else       s_axis_tready <= 1'b1;
  end
`endif

endmodule
